fminmax_unit_scheduler: RTL and testbench
=========================================

# fminmax_unit_scheduler

Round-robin scheduler that shares one floating-point min/max datapath (FLEN-wide FloPoCo-format operands, fixed latency) among NUM_REQ requesters in the FPU. It accepts requests over valid/ready handshakes, issues at most one operation per cycle to the shared unit, tags in-flight operations, and returns results in issue order through a credit-protected result FIFO with backpressure.

## Interface
- NUM_REQ, 4: number of requesters; must be ≥2.
- UNIT_LATENCY, 2: cycles from unit_valid to the matching unit_res; must be ≥0, and 0 means combinational.
- FIFO_DEPTH, 4: result FIFO entries. Any value ≥1 is correct. A value ≥ UNIT_LATENCY+2 gives full throughput.
- ID_W, 3: width of the requester-supplied tag.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  request accepted this cycle; one-hot or zero.
- req_a, req_b  in  NUM_REQ×FLEN  operands.
- req_is_max  in  NUM_REQ  1 = max, 0 = min.
- req_id  in  NUM_REQ×ID_W  opaque tag.
- unit_valid  out  1  operation issued to shared unit.
- unit_a, unit_b  out  FLEN  registered operands.
- unit_is_max  out  1  registered op select.
- unit_res  in  FLEN  unit result. Valid exactly UNIT_LATENCY cycles after unit_valid.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts.
- res_data  out  FLEN  result.
- res_src  out  $clog2(NUM_REQ)  originating requester.
- res_id  out  ID_W  echoed req_id.

## Operation
- Credit counter: range 0..FIFO_DEPTH, reset to FIFO_DEPTH.
  - Decrements on a grant.
  - Increments on a pop (res_valid & res_ready).
  - Grant and pop in the same cycle leave it unchanged.
  - No grant is made while credit = 0.
- Arbitration: among requesters with req_valid set, grant the first index found searching upward (with wrap) from last_grant+1.
  - last_grant resets to NUM_REQ-1, so index 0 has priority first.
  - last_grant updates only on a grant.
- req_ready[i] = grant[i], combinational from req_valid, credit and last_grant.
  - A handshake occurs when req_valid[i] & req_ready[i].
  - Requesters must hold their request stable until it is accepted.
- Issue stage: on a handshake, {a, b, is_max} load into the unit_* registers and unit_valid=1 the next cycle. Otherwise unit_valid=0 and the operand registers hold their values.
- Tag pipeline: a shift register of {valid, src, id}, UNIT_LATENCY deep, aligned with unit_valid.
  - When the tail entry is valid, {unit_res, src, id} is written to the FIFO.
  - Credits guarantee the FIFO is never written while full.
- FIFO: FIFO_DEPTH entries, first-word-fall-through from registered storage, in-order.
  - Simultaneous write and pop is legal at any occupancy.
  - A write and a pop in the same cycle at occupancy 1 must not produce a bubble.
- Reset, asynchronous, including mid-operation:
  - All of these drop immediately: req_ready=0, unit_valid=0, res_valid=0, all tag valids, FIFO empty.
  - Credit returns to FIFO_DEPTH and last_grant to NUM_REQ-1.
  - unit_a, unit_b, unit_is_max, res_data, res_src and res_id reset to 0.
  - In-flight operations are discarded. No stale result may appear after reset is released.

## Timing
- Handshake in cycle t, then unit_valid in t+1, then FIFO write in t+1+UNIT_LATENCY, then res_valid in t+2+UNIT_LATENCY.
- Throughput is 1 operation per cycle while credit > 0.
- A pop in cycle t frees its credit for a grant in cycle t itself.
- res_* hold stable while res_valid & !res_ready.

## Structure
- Shared package fminmax_sched_types (imports taiga_config for FLEN), containing:
  - typedef fminmax_tag_t {src, id};
  - typedef fminmax_result_t {data, tag};
  - function rr_next for the arbiter search.
- Sub-module fminmax_result_fifo: parameterised FIFO of fminmax_result_t.
- The shared min/max unit stays outside this block and connects via the unit_* ports.

## Test plan
- Single request: requester 2, max(1.0, 2.5), id 5, UNIT_LATENCY=2, handshake at cycle 10 → res_valid at cycle 14 with res_data=2.5, res_src=2, res_id=5.
- Min select: min(-3.0, 2.0) → res_data=-3.0.
- All 4 requesters continuously valid, res_ready=1 → grants 0,1,2,3,0,1… one per cycle; results arrive in the same order with no gaps.
- res_ready=0, FIFO_DEPTH=4 → exactly 4 handshakes, then req_ready=0 and credit=0. Pulse res_ready for 1 cycle → exactly one new grant in that same cycle, and credit stays 0.
- Credit=1 with a simultaneous pop and grant → credit stays 1, and the next cycle grants again.
- Assert rst with 3 operations in flight and 1 in the FIFO → outputs are 0 in the same cycle. After release, no res_valid until a new handshake, credit=FIFO_DEPTH, and requester 0 has priority.

Source files
------------

// File: rtl/fminmax_sched_types.sv
// Types and helpers shared by the min/max scheduler and its result FIFO.
package fminmax_sched_types;
  import taiga_config::*;

  // Tag field widths; the scheduler's NUM_REQ and ID_W must fit these.
  localparam int unsigned TAG_SRC_W = 2;
  localparam int unsigned TAG_ID_W  = 3;

  // Widest request vector the round-robin search handles.
  localparam int unsigned RR_MAX   = 32;
  localparam int unsigned RR_IDX_W = 5;

  typedef struct packed {
    logic [TAG_SRC_W-1:0] src;
    logic [TAG_ID_W-1:0]  id;
  } fminmax_tag_t;

  typedef struct packed {
    logic [FLEN-1:0] data;
    fminmax_tag_t    tag;
  } fminmax_result_t;

  // First set bit of valid[0..n-1], searching upward with wrap from last+1.
  // The result is meaningless when no bit is set; callers qualify with |valid.
  function automatic int unsigned rr_next(input logic [RR_MAX-1:0] valid,
                                          input int unsigned n,
                                          input int unsigned last);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = last + k;
      if (idx >= n) idx = idx - n;
      if ((k <= n) && !found && valid[idx[RR_IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/taiga_config.sv
// Processor-wide configuration shared by the FPU blocks.
package taiga_config;

  // FloPoCo single-precision operand width: 2 exception bits, sign, 8-bit exponent, 23-bit mantissa.
  localparam int unsigned FLEN = 34;

endpackage

// File: rtl/fminmax_result_fifo.sv
// In-order first-word-fall-through FIFO of min/max results, read from registered storage.
module fminmax_result_fifo
  import fminmax_sched_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wrValid_i,
  input  fminmax_result_t wrData_i,
  output logic            rdValid_o,
  input  logic            rdReady_i,
  output fminmax_result_t rdData_o
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNTW = $clog2(DEPTH + 1);

  fminmax_result_t mem_q [DEPTH];
  logic [PW-1:0]   rdPtr_q;
  logic [PW-1:0]   wrPtr_q;
  logic [CNTW-1:0] count_q;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptrNext(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push      = wrValid_i;
  assign pop       = rdReady_i && (count_q != '0);
  assign rdValid_o = (count_q != '0);
  assign rdData_o  = mem_q[rdPtr_q];

  // Storage, pointers and occupancy; a push and pop together keep the count so no bubble appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wrPtr_q] <= wrData_i;
        wrPtr_q        <= ptrNext(wrPtr_q);
      end
      if (pop) rdPtr_q <= ptrNext(rdPtr_q);
      if (push && !pop)      count_q <= count_q + CNTW'(1);
      else if (!push && pop) count_q <= count_q - CNTW'(1);
    end
  end

endmodule

// File: rtl/fminmax_unit_scheduler.sv
// Round-robin scheduler sharing one fixed-latency min/max unit among several requesters,
// returning results in issue order through a credit-protected result FIFO.
module fminmax_unit_scheduler
  import taiga_config::*;
  import fminmax_sched_types::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned UNIT_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ID_W         = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FLEN-1:0]   req_a,
  input  logic [NUM_REQ*FLEN-1:0]   req_b,
  input  logic [NUM_REQ-1:0]        req_is_max,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  output logic                      unit_valid,
  output logic [FLEN-1:0]           unit_a,
  output logic [FLEN-1:0]           unit_b,
  output logic                      unit_is_max,
  input  logic [FLEN-1:0]           unit_res,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [FLEN-1:0]           res_data,
  output logic [$clog2(NUM_REQ)-1:0] res_src,
  output logic [ID_W-1:0]           res_id
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grantIdx;
  logic               handshake;
  logic               pop;
  logic [SRC_W-1:0]   lastGrant_q;
  logic [CW-1:0]      credit_q;
  logic [CW-1:0]      credit_d;
  logic [FLEN-1:0]    selA;
  logic [FLEN-1:0]    selB;
  logic               selIsMax;
  logic [ID_W-1:0]    selId;
  logic               unitValid_q;
  logic [FLEN-1:0]    unitA_q;
  logic [FLEN-1:0]    unitB_q;
  logic               unitIsMax_q;
  fminmax_tag_t       issueTag_q;
  logic               fifoWrValid;
  fminmax_tag_t       fifoWrTag;
  fminmax_result_t    fifoWrData;
  fminmax_result_t    fifoRdData;

  // Grant one requester per cycle, held off during reset and while no credit is free;
  // a pop in this same cycle counts as a free credit.
  always_comb begin
    grant    = '0;
    grantIdx = SRC_W'(rr_next(RR_MAX'(req_valid), NUM_REQ, 32'(lastGrant_q)));
    if (!rst && (|req_valid) && ((credit_q != '0) || pop)) grant[grantIdx] = 1'b1;
  end

  assign req_ready = grant;
  assign handshake = |grant;
  assign pop       = res_valid && res_ready;

  // Steer the granted requester's operands and tag toward the issue registers.
  always_comb begin
    selA     = '0;
    selB     = '0;
    selIsMax = 1'b0;
    selId    = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant[i]) begin
        selA     = req_a[i*FLEN +: FLEN];
        selB     = req_b[i*FLEN +: FLEN];
        selIsMax = req_is_max[i];
        selId    = req_id[i*ID_W +: ID_W];
      end
    end
  end

  // Round-robin pointer moves only when something is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lastGrant_q <= SRC_W'(NUM_REQ - 1);
    else if (handshake) lastGrant_q <= grantIdx;
  end

  // One credit per FIFO slot: consumed on grant, returned on pop.
  always_comb begin
    credit_d = credit_q;
    if (handshake && !pop)      credit_d = credit_q - CW'(1);
    else if (!handshake && pop) credit_d = credit_q + CW'(1);
  end

  // Credit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) credit_q <= CW'(FIFO_DEPTH);
    else     credit_q <= credit_d;
  end

  // Issue stage: operands pulse into the shared unit the cycle after a handshake and hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unitValid_q <= 1'b0;
      unitA_q     <= '0;
      unitB_q     <= '0;
      unitIsMax_q <= 1'b0;
      issueTag_q  <= '0;
    end else begin
      unitValid_q <= handshake;
      if (handshake) begin
        unitA_q        <= selA;
        unitB_q        <= selB;
        unitIsMax_q    <= selIsMax;
        issueTag_q.src <= TAG_SRC_W'(grantIdx);
        issueTag_q.id  <= TAG_ID_W'(selId);
      end
    end
  end

  assign unit_valid  = unitValid_q;
  assign unit_a      = unitA_q;
  assign unit_b      = unitB_q;
  assign unit_is_max = unitIsMax_q;

  generate
    if (UNIT_LATENCY == 0) begin : g_combUnit
      assign fifoWrValid = unitValid_q;
      assign fifoWrTag   = issueTag_q;
    end else begin : g_tagPipe
      logic [UNIT_LATENCY-1:0] pipeValid_q;
      fminmax_tag_t            pipeTag_q [UNIT_LATENCY];

      // Tags follow their operation through the unit so the tail lines up with unit_res.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pipeValid_q <= '0;
          for (int i = 0; i < int'(UNIT_LATENCY); i++) pipeTag_q[i] <= '0;
        end else begin
          pipeValid_q[0] <= unitValid_q;
          pipeTag_q[0]   <= issueTag_q;
          for (int i = 1; i < int'(UNIT_LATENCY); i++) begin
            pipeValid_q[i] <= pipeValid_q[i-1];
            pipeTag_q[i]   <= pipeTag_q[i-1];
          end
        end
      end

      assign fifoWrValid = pipeValid_q[UNIT_LATENCY-1];
      assign fifoWrTag   = pipeTag_q[UNIT_LATENCY-1];
    end
  endgenerate

  assign fifoWrData.data = unit_res;
  assign fifoWrData.tag  = fifoWrTag;

  fminmax_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_resultFifo (
    .clk      (clk),
    .rst      (rst),
    .wrValid_i(fifoWrValid),
    .wrData_i (fifoWrData),
    .rdValid_o(res_valid),
    .rdReady_i(res_ready),
    .rdData_o (fifoRdData)
  );

  assign res_data = fifoRdData.data;
  assign res_src  = SRC_W'(fifoRdData.tag.src);
  assign res_id   = ID_W'(fifoRdData.tag.id);

endmodule

// File: tb/tb_fminmax_unit_scheduler.sv
// Directed bench for the min/max scheduler, with a 2-cycle behavioural min/max unit attached.
module tb_fminmax_unit_scheduler;
  import taiga_config::*;

  localparam int unsigned NR   = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDW  = 3;

  localparam logic [FLEN-1:0] FP_1_0  = {2'b01, 32'h3F80_0000};
  localparam logic [FLEN-1:0] FP_2_5  = {2'b01, 32'h4020_0000};
  localparam logic [FLEN-1:0] FP_N3_0 = {2'b01, 32'hC040_0000};
  localparam logic [FLEN-1:0] FP_2_0  = {2'b01, 32'h4000_0000};

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*FLEN-1:0]   req_a;
  logic [NR*FLEN-1:0]   req_b;
  logic [NR-1:0]        req_is_max;
  logic [NR*IDW-1:0]    req_id;
  logic                 unit_valid;
  logic [FLEN-1:0]      unit_a;
  logic [FLEN-1:0]      unit_b;
  logic                 unit_is_max;
  logic [FLEN-1:0]      unit_res;
  logic                 res_valid;
  logic                 res_ready;
  logic [FLEN-1:0]      res_data;
  logic [1:0]           res_src;
  logic [IDW-1:0]       res_id;

  int total = 0;
  int bad   = 0;

  fminmax_unit_scheduler #(
    .NUM_REQ(NR), .UNIT_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .ID_W(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_is_max(req_is_max), .req_id(req_id),
    .unit_valid(unit_valid), .unit_a(unit_a), .unit_b(unit_b), .unit_is_max(unit_is_max),
    .unit_res(unit_res),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_id(res_id)
  );

  always #5 clk = ~clk;

  // Reference min/max on FloPoCo normals: order by sign, then by exponent/mantissa magnitude.
  function automatic logic [FLEN-1:0] fpMinMax(input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
                                               input logic isMax);
    logic aLess;
    if (a[31] != b[31])  aLess = a[31];
    else if (!a[31])     aLess = (a[30:0] < b[30:0]);
    else                 aLess = (a[30:0] > b[30:0]);
    return (isMax ^ aLess) ? a : b;
  endfunction

  // Shared unit model: result appears exactly LAT cycles after unit_valid.
  logic [FLEN-1:0] stage1;
  logic [FLEN-1:0] stage2;
  always @(posedge clk) begin
    stage1 <= fpMinMax(unit_a, unit_b, unit_is_max);
    stage2 <= stage1;
  end
  assign unit_res = stage2;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int idx, input logic [FLEN-1:0] a, input logic [FLEN-1:0] b,
                               input logic isMax, input logic [IDW-1:0] id);
    req_a[idx*FLEN +: FLEN] = a;
    req_b[idx*FLEN +: FLEN] = b;
    req_is_max[idx]         = isMax;
    req_id[idx*IDW +: IDW]  = id;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  int lat;
  int hs;
  int pops;
  int stale;

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_is_max = '0;
    req_id     = '0;
    res_ready  = 1'b1;

    // Reset state, with requests already pending.
    nextCycle();
    req_valid = 4'hF;
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_unit_valid", 64'(unit_valid), 64'(0));
    checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("rst_res_data", 64'(res_data), 64'(0));
    checkOutput("rst_credit", 64'(dut.credit_q), 64'(DEPTH));
    nextCycle();
    rst       = 1'b0;
    req_valid = '0;
    nextCycle();

    // Single request: requester 2, max(1.0, 2.5), id 5.
    $display("[TB] single max request");
    applyStimulus(2, FP_1_0, FP_2_5, 1'b1, 3'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("single_ready", 64'(req_ready), 64'(4'b0100));
    nextCycle();
    req_valid = '0;
    @(negedge clk);
    checkOutput("single_unit_valid", 64'(unit_valid), 64'(1));
    checkOutput("single_unit_a", 64'(unit_a), 64'(FP_1_0));
    checkOutput("single_unit_b", 64'(unit_b), 64'(FP_2_5));
    checkOutput("single_unit_is_max", 64'(unit_is_max), 64'(1));
    nextCycle();
    @(negedge clk);
    checkOutput("single_unit_valid_drop", 64'(unit_valid), 64'(0));
    checkOutput("single_early_t2", 64'(res_valid), 64'(0));
    nextCycle();
    @(negedge clk);
    checkOutput("single_early_t3", 64'(res_valid), 64'(0));
    nextCycle();
    @(negedge clk);
    checkOutput("single_res_valid", 64'(res_valid), 64'(1));
    checkOutput("single_res_data", 64'(res_data), 64'(FP_2_5));
    checkOutput("single_res_src", 64'(res_src), 64'(2));
    checkOutput("single_res_id", 64'(res_id), 64'(5));
    nextCycle();
    @(negedge clk);
    checkOutput("single_popped", 64'(res_valid), 64'(0));

    // Min select: requester 1, min(-3.0, 2.0), id 3.
    $display("[TB] min request");
    nextCycle();
    applyStimulus(1, FP_N3_0, FP_2_0, 1'b0, 3'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("min_ready", 64'(req_ready), 64'(4'b0010));
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      nextCycle();
      req_valid = '0;
      @(negedge clk);
      if (res_valid) begin
        lat = c;
        break;
      end
    end
    checkOutput("min_latency", 64'(lat), 64'(4));
    checkOutput("min_res_data", 64'(res_data), 64'(FP_N3_0));
    checkOutput("min_res_src", 64'(res_src), 64'(1));
    checkOutput("min_res_id", 64'(res_id), 64'(3));

    // All requesters valid; last grant was 1, so the rotation runs 2,3,0,1,...
    $display("[TB] round-robin streaming");
    for (int i = 0; i < int'(NR); i++)
      applyStimulus(i, FP_1_0, FP_2_5, i[0], IDW'(i + 1));
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      req_valid = (k < 8) ? 4'hF : 4'h0;
      @(negedge clk);
      if (k < 8) checkOutput("rr_grant", 64'(req_ready), 64'(4'b0001 << ((2 + k) % 4)));
      if (k >= 4) begin
        checkOutput("rr_res_valid", 64'(res_valid), 64'(1));
        checkOutput("rr_res_src", 64'(res_src), 64'((2 + k - 4) % 4));
        checkOutput("rr_res_id", 64'(res_id), 64'(((2 + k - 4) % 4) + 1));
        checkOutput("rr_res_data", 64'(res_data), 64'((((2 + k - 4) % 4) % 2 == 1) ? FP_2_5 : FP_1_0));
      end
    end
    nextCycle();
    @(negedge clk);
    checkOutput("rr_drained", 64'(res_valid), 64'(0));

    // Backpressure: four credits, then a one-cycle pop lets exactly one new grant through.
    $display("[TB] credit exhaustion");
    res_ready = 1'b0;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      nextCycle();
      req_valid = 4'hF;
      @(negedge clk);
      hs += $countones(req_ready & req_valid);
    end
    checkOutput("bp_handshakes", 64'(hs), 64'(4));
    checkOutput("bp_ready_zero", 64'(req_ready), 64'(0));
    checkOutput("bp_credit_zero", 64'(dut.credit_q), 64'(0));
    checkOutput("bp_head_src", 64'(res_src), 64'(2));
    nextCycle();
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_pulse_grant", 64'(req_ready), 64'(4'b0100));
    nextCycle();
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_after_ready", 64'(req_ready), 64'(0));
    checkOutput("bp_after_credit", 64'(dut.credit_q), 64'(0));
    checkOutput("bp_next_src", 64'(res_src), 64'(3));
    pops = 0;
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      req_valid = '0;
      res_ready = 1'b1;
      @(negedge clk);
      if (res_valid) pops++;
    end
    checkOutput("bp_drain_pops", 64'(pops), 64'(4));
    checkOutput("bp_drain_credit", 64'(dut.credit_q), 64'(DEPTH));

    // Credit at 1 with a simultaneous pop and grant stays at 1 and grants again.
    $display("[TB] credit one with pop and grant");
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      req_valid = 4'b0001;
    end
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      req_valid = '0;
    end
    @(negedge clk);
    checkOutput("c1_credit_before", 64'(dut.credit_q), 64'(1));
    checkOutput("c1_fifo_nonempty", 64'(res_valid), 64'(1));
    nextCycle();
    req_valid = 4'b0001;
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("c1_grant", 64'(req_ready), 64'(4'b0001));
    nextCycle();
    @(negedge clk);
    checkOutput("c1_credit_kept", 64'(dut.credit_q), 64'(1));
    checkOutput("c1_grant_again", 64'(req_ready), 64'(4'b0001));
    for (int k = 0; k < 12; k++) begin
      nextCycle();
      req_valid = '0;
    end
    @(negedge clk);
    checkOutput("c1_drain_credit", 64'(dut.credit_q), 64'(DEPTH));
    checkOutput("c1_drain_empty", 64'(res_valid), 64'(0));

    // Asynchronous reset with three operations in flight and one waiting in the FIFO.
    $display("[TB] reset mid-operation");
    res_ready = 1'b0;
    hs = 0;
    for (int k = 0; k < 4; k++) begin
      nextCycle();
      applyStimulus(0, FP_2_0, FP_1_0, 1'b1, IDW'(k));
      req_valid = 4'b0001;
      @(negedge clk);
      hs += $countones(req_ready);
    end
    nextCycle();
    req_valid = '0;
    @(negedge clk);
    checkOutput("mid_handshakes", 64'(hs), 64'(4));
    checkOutput("mid_fifo_has_one", 64'(res_valid), 64'(1));
    checkOutput("mid_unit_busy", 64'(unit_valid), 64'(1));
    #2;
    rst       = 1'b1;
    req_valid = 4'hF;
    #1;
    checkOutput("mid_rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("mid_rst_unit_valid", 64'(unit_valid), 64'(0));
    checkOutput("mid_rst_res_valid", 64'(res_valid), 64'(0));
    checkOutput("mid_rst_res_data", 64'(res_data), 64'(0));
    checkOutput("mid_rst_res_src", 64'(res_src), 64'(0));
    checkOutput("mid_rst_res_id", 64'(res_id), 64'(0));
    checkOutput("mid_rst_unit_a", 64'(unit_a), 64'(0));
    checkOutput("mid_rst_unit_is_max", 64'(unit_is_max), 64'(0));
    nextCycle();
    nextCycle();
    rst       = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (res_valid || unit_valid) stale++;
      nextCycle();
    end
    checkOutput("post_rst_no_stale", 64'(stale), 64'(0));
    checkOutput("post_rst_credit", 64'(dut.credit_q), 64'(DEPTH));
    req_valid = 4'hF;
    @(negedge clk);
    checkOutput("post_rst_priority", 64'(req_ready), 64'(4'b0001));
    nextCycle();
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
